// File: rtl/ama_riscv_fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding/scoreboard slice: register
// address type, paired-register mapping and width helpers.
package ama_riscv_defines;

  typedef logic [4:0] rf_addr_t;

  localparam rf_addr_t RF_X0_ZERO = 5'd0;

  // Default maximum execute latency used to size sb_cnt_t
  localparam int SB_MAX_LAT_DEF = 4;

  typedef logic [$clog2(SB_MAX_LAT_DEF+1)-1:0] sb_cnt_t;

  // Paired destination: the odd register of the even/odd pair holding rd.
  // An odd rd therefore pairs with itself.
  function automatic rf_addr_t get_rdp(input rf_addr_t rd);
    return {rd[4:1], 1'b1};
  endfunction

  // Width of one forward select: 0 = RF, 1..num_fwd = forwarding stage
  function automatic int fwd_sel_width(input int num_fwd);
    return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/ama_riscv_fwd_scoreboard_match.sv
// Priority matcher for one source operand over all forwarding stages.
// Youngest stage (lowest index) wins; within a stage rd beats rdp.
module ama_riscv_fwd_match
  import ama_riscv_defines::*;
#(
  parameter int NUM_FWD = 2,
  parameter int PAIRED  = 1,
  parameter int FSEL_W  = fwd_sel_width(NUM_FWD)
) (
  input  logic [4:0]           rs_addr,
  input  logic                 rs_used,
  input  logic [NUM_FWD*5-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]   fwd_rd_we,
  input  logic [NUM_FWD-1:0]   fwd_rdp_we,
  output logic [FSEL_W-1:0]    fwd_sel,
  output logic                 on_rdp
);

  // Walk from oldest to youngest so the youngest match is the last write
  always_comb begin
    fwd_sel = '0;
    on_rdp  = 1'b0;
    if (rs_used && (rs_addr != RF_X0_ZERO)) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_rd_we[k] && (fwd_rd[5*k +: 5] == rs_addr)) begin
          fwd_sel = FSEL_W'(k + 1);
          on_rdp  = 1'b0;
        end else if ((PAIRED != 0) && fwd_rdp_we[k] &&
                     (get_rdp(fwd_rd[5*k +: 5]) == rs_addr)) begin
          fwd_sel = FSEL_W'(k + 1);
          on_rdp  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ama_riscv_fwd_scoreboard.sv
// Operand forwarding with a per-register latency scoreboard. cnt[r] holds
// the cycles until r's result reaches forwarding stage 0; decode stalls
// while any used source still has a non-zero count.
module ama_riscv_fwd_scoreboard
  import ama_riscv_defines::*;
#(
  parameter int NUM_RS  = 2,
  parameter int NUM_FWD = 2,
  parameter int MAX_LAT = 4,
  parameter int PAIRED  = 1,
  parameter int LAT_W   = $clog2(MAX_LAT + 1),
  parameter int FSEL_W  = fwd_sel_width(NUM_FWD)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_rd,
  input  logic                       issue_rd_we,
  input  logic                       issue_rdp_we,
  input  logic [LAT_W-1:0]           issue_lat,
  input  logic                       flush,
  input  logic [NUM_RS*5-1:0]        rs_addr,
  input  logic [NUM_RS-1:0]          rs_used,
  input  logic [NUM_FWD*5-1:0]       fwd_rd,
  input  logic [NUM_FWD-1:0]         fwd_rd_we,
  input  logic [NUM_FWD-1:0]         fwd_rdp_we,
  output logic [NUM_RS*FSEL_W-1:0]   fwd_sel,
  output logic [NUM_RS-1:0]          fwd_on_rdp,
  output logic                       stall,
  output logic [5:0]                 busy_cnt
);

  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] ONE_C     = LAT_W'(1);

  // Entry 0 exists only so x0 can be indexed; it is held at zero
  logic [LAT_W-1:0] cnt_q [32];
  logic [LAT_W-1:0] cnt_d [32];
  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] new_cnt;
  rf_addr_t         issue_rdp;
  logic             wr_rd;
  logic             wr_rdp;

  // Clamp the issued latency to 1..MAX_LAT and derive the write enables
  always_comb begin
    if (issue_lat == '0) begin
      lat_eff = ONE_C;
    end else if (issue_lat > MAX_LAT_C) begin
      lat_eff = MAX_LAT_C;
    end else begin
      lat_eff = issue_lat;
    end
    new_cnt   = lat_eff - ONE_C;
    issue_rdp = get_rdp(issue_rd);
    wr_rd     = issue_valid && !flush && issue_rd_we &&
                (issue_rd != RF_X0_ZERO);
    wr_rdp    = (PAIRED != 0) && issue_valid && !flush && issue_rdp_we &&
                (issue_rdp != RF_X0_ZERO);
  end

  // Decrement every live count, then let a new issue overwrite its entry
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - ONE_C;
      end
      if ((wr_rd && (issue_rd == 5'(r))) || (wr_rdp && (issue_rdp == 5'(r)))) begin
        cnt_d[r] = new_cnt;
      end
      if (r == 0) begin
        cnt_d[r] = '0;
      end
    end
  end

  // Scoreboard state register; reset drops every pending entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Stall when any used, non-x0 source is still in flight
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_used[i] && (rs_addr[5*i +: 5] != RF_X0_ZERO) &&
          (cnt_q[rs_addr[5*i +: 5]] != '0)) begin
        stall = 1'b1;
      end
    end
  end

  // Count the live scoreboard entries
  always_comb begin
    busy_cnt = '0;
    for (int r = 1; r < 32; r++) begin
      if (cnt_q[r] != '0) begin
        busy_cnt = busy_cnt + 6'd1;
      end
    end
  end

  // One priority matcher per source operand
  for (genvar g = 0; g < NUM_RS; g++) begin : g_match
    ama_riscv_fwd_match #(
      .NUM_FWD (NUM_FWD),
      .PAIRED  (PAIRED),
      .FSEL_W  (FSEL_W)
    ) u_match (
      .rs_addr    (rs_addr[5*g +: 5]),
      .rs_used    (rs_used[g]),
      .fwd_rd     (fwd_rd),
      .fwd_rd_we  (fwd_rd_we),
      .fwd_rdp_we (fwd_rdp_we),
      .fwd_sel    (fwd_sel[FSEL_W*g +: FSEL_W]),
      .on_rdp     (fwd_on_rdp[g])
    );
  end

endmodule

// File: doc/ama_riscv_fwd_scoreboard.md
Name: ama_riscv_fwd_scoreboard

Overview:
Parametrised successor to the fixed mem/wbk operand-forwarding unit. It generalises forwarding to NUM_RS source operands and NUM_FWD forwarding stages. It adds a per-register latency scoreboard for variable-latency execute ops (load, mult, multi-cycle SIMD), including paired-register (rdp) writes. It sits beside the DEC/EXE boundary and produces per-operand forward selects plus a single decode stall.

Parameters:
NUM_RS, 2, number of source operands checked per instruction
NUM_FWD, 2, number of forwarding stages after EXE; stage 0 is youngest (MEM), stage NUM_FWD-1 is oldest
MAX_LAT, 4, maximum execute latency in cycles; must be >= 1
PAIRED, 1, 1 = track and forward paired destination rdp = get_rdp(rd); 0 = rdp inputs ignored
LAT_W, $clog2(MAX_LAT+1), width of the latency field
FSEL_W, $clog2(NUM_FWD+1), width of each forward select

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
issue_valid  in  1  instruction leaving EXE this cycle
issue_rd  in  5  destination register
issue_rd_we  in  1  rd is written
issue_rdp_we  in  1  paired rdp is written
issue_lat  in  LAT_W  execute latency; 1 = single-cycle op
flush  in  1  cancels this cycle's issue only
rs_addr  in  NUM_RS*5  decode source addresses, operand i at [5i+:5]
rs_used  in  NUM_RS  operand i is actually read (ALU, branch or store)
fwd_rd  in  NUM_FWD*5  rd held in each forwarding stage
fwd_rd_we  in  NUM_FWD  stage rd write enable
fwd_rdp_we  in  NUM_FWD  stage rdp write enable
fwd_sel  out  NUM_RS*FSEL_W  per operand: 0 = RF, k = forwarding stage k-1
fwd_on_rdp  out  NUM_RS  per operand: selected stage matched on rdp, not rd
stall  out  1  hold DEC, inject a bubble into EXE
busy_cnt  out  6  number of scoreboard entries with a non-zero count

Behaviour:
- State: cnt[1..31], each LAT_W bits. x0 has no entry and always reads 0.
- Definition: cnt[r] = cycles until r's value reaches forwarding stage 0. cnt == 0 means the value is available from a forwarding stage or from the RF.
- Per-cycle update, in this order:
  1. All non-zero counts decrement by 1.
  2. If issue_valid && !flush && issue_rd_we && issue_rd != 0, then cnt[issue_rd] = min(issue_lat, MAX_LAT) - 1.
  3. Same rule for the rdp entry when PAIRED && issue_rdp_we && rdp != 0.
- A write (step 2/3) overrides a same-cycle decrement on the same entry. A WAW re-issue overwrites the older count.
- issue_lat == 0 is treated as 1. Values above MAX_LAT saturate to MAX_LAT.
- rd == rdp (rdp equal to rd) results in a single write.
- stall is combinational: OR over i of (rs_used[i] && rs_addr[i] != 0 && cnt[rs_addr[i]] != 0).
- With issue_lat = 2 (load/mult), a dependent instruction immediately behind it sees cnt = 1 and stalls exactly 1 cycle. This matches the legacy two-clock hazard.
- fwd_sel[i] selects the youngest stage k (lowest index) where:
  - fwd_rd[k] == rs_addr[i] && fwd_rd_we[k], or
  - PAIRED && get_rdp(fwd_rd[k]) == rs_addr[i] && fwd_rdp_we[k].
  Select value is k+1. fwd_on_rdp[i] is set if the winning match was on rdp.
- rs_addr == 0 or !rs_used[i] forces fwd_sel[i] = 0 and fwd_on_rdp[i] = 0.
- If rd and rdp in the same stage both match (impossible when rd != rdp), rd wins.
- While stall is high, fwd_sel is still driven. The consumer must ignore it.
- Issue is not blocked by stall; the pipeline supplies issue_valid = 0 for bubbles.
- busy_cnt = popcount(cnt[r] != 0), combinational from registered state.
- Reset clears all cnt. As a result: stall = 0, busy_cnt = 0, and fwd_sel depends only on the fwd_* inputs.
- Reset mid-operation drops all pending entries in the same edge.
- flush does not clear existing entries, because they belong to older, committed instructions.

Decomposition:
- Shared package (ama_riscv_defines): rf_addr_t, RF_X0_ZERO, get_rdp(), a fwd_sel_t width helper, and sb_cnt_t.
- Sub-module ama_riscv_fwd_match: one operand's priority matcher over NUM_FWD stages. Instantiated NUM_RS times via generate.
- The scoreboard array and the stall OR-reduce stay in the top module.

Test Plan:
- Load x5 (lat=2), then add rs1=x5 next cycle → stall=1 for 1 cycle. Next cycle stall=0 and, with fwd_rd[0]=5, fwd_we[0]=1, fwd_sel[0]=1.
- x7 present in stage 0 and stage 1 (both we=1), rs_addr[1]=7 → fwd_sel[1]=1 (youngest wins). Stage-0 we=0 → fwd_sel[1]=2.
- Paired mult rd=x10, rdp=x11, lat=3; consumer reads x11 → stall 2 cycles, then fwd_on_rdp=1, fwd_sel=1. With PAIRED=0 → x11 is never stalled or forwarded.
- Issue with rd=0, lat=4 → busy_cnt stays 0. Consumer with rs=x0 and rs_used=1 → stall=0, fwd_sel=0.
- Issue x3 lat=4 and flush in the same cycle → no entry. Issue x3 lat=4, then re-issue x3 lat=1 next cycle → cnt[3]=0, busy_cnt drops to 0.
- Issue x9 lat=4, assert rst one cycle later → next cycle busy_cnt=0, stall=0 for rs=x9; issue_lat=7 with MAX_LAT=4 → cnt[9]=3.
